// File: rtl/gray2bin_tracker_if.sv
// ---------------------------------------------------------------------------
// gray2bin_tracker_if
// Bundles the sample input handshake, the decoded-result output handshake
// and the error-counter controls of gray2bin_tracker.
//   in_val / in_rdy / in_       : Gray-coded sample stream into the tracker
//   out_val / out_rdy           : decoded result stream out of the tracker
//   out / out_step              : binary value and step class of the result
//   err_clr / err_count         : clear strobe and saturating ERR counter
// master = the environment around the tracker, slave = the tracker itself.
// ---------------------------------------------------------------------------
interface gray2bin_tracker_if #(
    parameter int NBITS     = 4,
    parameter int ECNT_BITS = 8
);
    logic                 in_val;
    logic                 in_rdy;
    logic [NBITS-1:0]     in_;
    logic                 out_val;
    logic                 out_rdy;
    logic [NBITS-1:0]     out;
    logic [1:0]           out_step;
    logic                 err_clr;
    logic [ECNT_BITS-1:0] err_count;

    modport master (
        output in_val, in_, out_rdy, err_clr,
        input  in_rdy, out_val, out, out_step, err_count
    );

    modport slave (
        input  in_val, in_, out_rdy, err_clr,
        output in_rdy, out_val, out, out_step, err_count
    );
endinterface

// File: rtl/gray2bin_tracker.sv
// ---------------------------------------------------------------------------
// gray2bin_tracker
// Decodes a stream of Gray-coded samples to binary and classifies each step
// relative to the previous accepted sample as HOLD(0), UP(1), DOWN(2) or
// ERR(3, multi-count jump). Results leave through a one-entry registered
// val/rdy stage; ERR steps are tallied in a saturating counter.
// Ports:
//   clk    : clock, all state changes on its rising edge
//   reset  : asynchronous active-high reset
//   bus    : gray2bin_tracker_if.slave (sample in, result out, err counter)
// ---------------------------------------------------------------------------
module gray2bin_tracker #(
    parameter int NBITS     = 4,
    parameter int ECNT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    gray2bin_tracker_if.slave   bus
);

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    logic                 r_out_val;
    logic [NBITS-1:0]     r_out;
    step_e                r_out_step;
    logic [NBITS-1:0]     r_prev_bin;
    logic                 r_have_prev;
    logic [ECNT_BITS-1:0] r_err_count;

    logic [NBITS-1:0]     w_bin;
    logic [NBITS-1:0]     w_diff;
    logic                 w_in_rdy;
    logic                 w_accept;
    logic                 w_fire;
    logic                 w_err_inc;
    step_e                w_step;

    // Binary bit i is the XOR of all Gray bits at and above i; written as a
    // reduction per bit so there is no bit-to-bit chain inside one vector.
    generate
        for (genvar gi = 0; gi < NBITS; gi++) begin : g_decode
            assign w_bin[gi] = ^bus.in_[NBITS-1:gi];
        end
    endgenerate

    // The output slot can take a new result when empty or being drained now.
    assign w_in_rdy  = !r_out_val || bus.out_rdy;
    assign w_accept  = bus.in_val && w_in_rdy;
    assign w_fire    = r_out_val && bus.out_rdy;

    // Modular difference makes wrap-around steps look like +1 / -1.
    assign w_diff = w_bin - r_prev_bin;

    always_comb begin
        w_step = STEP_ERR;
        if (!r_have_prev || w_diff == '0) begin
            w_step = STEP_HOLD;
        end else if (w_diff == NBITS'(1)) begin
            w_step = STEP_UP;
        end else if (w_diff == '1) begin
            w_step = STEP_DOWN;
        end
    end

    assign w_err_inc = w_accept && (w_step == STEP_ERR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_val   <= 1'b0;
            r_out       <= '0;
            r_out_step  <= STEP_HOLD;
            r_prev_bin  <= '0;
            r_have_prev <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_accept) begin
                // Also covers fire+accept in one cycle: new result overwrites.
                r_out_val   <= 1'b1;
                r_out       <= w_bin;
                r_out_step  <= w_step;
                r_prev_bin  <= w_bin;
                r_have_prev <= 1'b1;
            end else if (w_fire) begin
                r_out_val   <= 1'b0;
            end

            // A clear coinciding with an ERR accept leaves that ERR counted.
            if (bus.err_clr) begin
                r_err_count <= w_err_inc ? ECNT_BITS'(1) : '0;
            end else if (w_err_inc && r_err_count != '1) begin
                r_err_count <= r_err_count + ECNT_BITS'(1);
            end
        end
    end

    assign bus.in_rdy    = w_in_rdy;
    assign bus.out_val   = r_out_val;
    assign bus.out       = r_out;
    assign bus.out_step  = r_out_step;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_gray2bin_tracker.sv
// ---------------------------------------------------------------------------
// tb_gray2bin_tracker
// Drives two trackers (8-bit and 2-bit error counters) with identical
// stimulus and compares them against a behavioural model: the decode is done
// by searching for the binary value whose Gray code matches, and steps are
// classified from an integer modular difference.
// ---------------------------------------------------------------------------
module tb_gray2bin_tracker;
    localparam int NB = 4;
    localparam int MOD = 1 << NB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gray2bin_tracker_if #(.NBITS(NB), .ECNT_BITS(8)) bus_a ();
    gray2bin_tracker_if #(.NBITS(NB), .ECNT_BITS(2)) bus_b ();

    gray2bin_tracker #(.NBITS(NB), .ECNT_BITS(8)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    gray2bin_tracker #(.NBITS(NB), .ECNT_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_oval, m_out, m_step, m_prev, m_have, m_err8, m_err2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int gray_to_bin(input int g);
        int b = -1;
        for (int c = 0; c < MOD; c++)
            if (((c ^ (c >> 1)) & (MOD - 1)) == g) b = c;
        return b;
    endfunction

    task automatic model_reset();
        m_oval = 0; m_out = 0; m_step = 0; m_prev = 0; m_have = 0;
        m_err8 = 0; m_err2 = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_val"},   32'(bus_a.out_val),   32'(m_oval));
        chk({tag, ".out"},       32'(bus_a.out),       32'(m_out));
        chk({tag, ".out_step"},  32'(bus_a.out_step),  32'(m_step));
        chk({tag, ".err8"},      32'(bus_a.err_count), 32'(m_err8));
        chk({tag, ".err2"},      32'(bus_b.err_count), 32'(m_err2));
        chk({tag, ".b_out"},     32'(bus_b.out),       32'(m_out));
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic cyc(input string tag, input bit v, input int g, input bit ordy, input bit clr);
        bit exp_rdy, acc, is_err;
        int b, d, st;
        bus_a.in_val = v; bus_a.in_ = NB'(g); bus_a.out_rdy = ordy; bus_a.err_clr = clr;
        bus_b.in_val = v; bus_b.in_ = NB'(g); bus_b.out_rdy = ordy; bus_b.err_clr = clr;
        #2;
        exp_rdy = (m_oval == 0) || ordy;
        chk({tag, ".in_rdy"}, 32'(bus_a.in_rdy), 32'(exp_rdy));
        acc = v && exp_rdy;
        is_err = 0;
        if (acc) begin
            b = gray_to_bin(g);
            d = (b - m_prev + MOD) % MOD;
            if (m_have == 0 || d == 0) st = 0;
            else if (d == 1)           st = 1;
            else if (d == MOD - 1)     st = 2;
            else                       st = 3;
            is_err = (st == 3);
            m_oval = 1; m_out = b; m_step = st; m_prev = b; m_have = 1;
        end else if (m_oval != 0 && ordy) begin
            m_oval = 0;
        end
        if (clr) begin
            m_err8 = is_err ? 1 : 0;
            m_err2 = is_err ? 1 : 0;
        end else if (is_err) begin
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3)   m_err2++;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        $display("cyc %-6s v=%0d g=%h ordy=%0d clr=%0d acc=%0d -> out_val=%0d out=%0d step=%0d err=%0d/%0d",
                 tag, v, g, ordy, clr, acc, bus_a.out_val, bus_a.out, bus_a.out_step,
                 bus_a.err_count, bus_b.err_count);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the edge.
    task automatic do_reset(input string tag);
        #1;
        reset = 1'b1;
        #1;
        chk({tag, ".async_oval"}, 32'(bus_a.out_val),   32'd0);
        chk({tag, ".async_err"},  32'(bus_a.err_count), 32'd0);
        $display("rst %-6s out_val=%0d err=%0d", tag, bus_a.out_val, bus_a.err_count);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int rb, nb, r;
        model_reset();
        bus_a.in_val = 0; bus_a.in_ = '0; bus_a.out_rdy = 0; bus_a.err_clr = 0;
        bus_b.in_val = 0; bus_b.in_ = '0; bus_b.out_rdy = 0; bus_b.err_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs("reset");
        cyc("idle", 0, 0, 0, 0);

        // Counting stream 0..4
        cyc("s0", 1, 4'b0000, 1, 0);
        cyc("s1", 1, 4'b0001, 1, 0);
        cyc("s2", 1, 4'b0011, 1, 0);
        cyc("s3", 1, 4'b0010, 1, 0);
        cyc("s4", 1, 4'b0110, 1, 0);
        cyc("s5", 0, 0, 1, 0);

        // Wrap-around
        do_reset("rw");
        cyc("w0", 1, 4'b1000, 1, 0);
        cyc("w1", 1, 4'b0000, 1, 0);
        cyc("w2", 1, 4'b1000, 1, 0);
        cyc("w3", 1, 4'b1000, 1, 0);

        // Error, resync and clear interaction
        do_reset("re");
        cyc("e0", 1, 4'b0000, 1, 0);
        cyc("e1", 1, 4'b0011, 1, 0);
        cyc("e2", 1, 4'b0010, 1, 0);
        cyc("e3", 1, 4'b0000, 1, 1);
        cyc("e4", 0, 0, 1, 1);
        cyc("e5", 0, 0, 1, 0);

        // Backpressure with a pending result, then release
        do_reset("rb");
        cyc("b0", 1, 4'b0000, 1, 0);
        cyc("b1", 1, 4'b0001, 0, 0);
        for (int i = 0; i < 5; i++) cyc("bhold", 1, 4'b0011, 0, 0);
        cyc("brel", 1, 4'b0011, 1, 0);
        cyc("bidle", 0, 0, 1, 0);
        cyc("bpend", 1, 4'b0010, 0, 0);
        do_reset("rmid");

        // Counter saturation: every step after the first is a jump
        for (int i = 0; i < 5; i++) begin
            cyc("sat0", 1, 4'b0000, 1, 0);
            cyc("sat5", 1, 4'b0101, 1, 0);
        end

        // Randomised walk with occasional jumps, stalls and clears
        do_reset("rr");
        rb = 0;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 2)      nb = rb;
            else if (r <= 5) nb = (rb + 1) % MOD;
            else if (r <= 8) nb = (rb + MOD - 1) % MOD;
            else             nb = int'($urandom_range(0, MOD - 1));
            rb = nb;
            cyc("rnd", $urandom_range(0, 4) != 0, nb ^ (nb >> 1),
                $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray2bin_tracker.md
Name: gray2bin_tracker

Overview:
Receive-side companion to the binary-to-Gray encoder. It accepts a stream of Gray-coded samples, such as a position encoder or a synchronized pointer. It decodes each sample to binary and classifies the step from the previous sample as hold, up, down or illegal multi-bit jump. Decoded results go out through a one-entry registered val/rdy output stage, and a saturating error counter is maintained.

Parameters:
NBITS, 4, width of the Gray input and the binary output; legal range NBITS >= 2.
ECNT_BITS, 8, width of the saturating error counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_val  input  1  input sample valid.
in_rdy  output  1  block can accept a sample this cycle.
in_  input  NBITS  Gray-coded sample.
out_val  output  1  decoded result valid.
out_rdy  input  1  downstream accepts the result.
out  output  NBITS  binary value of the accepted sample.
out_step  output  2  step class: 0 HOLD, 1 UP, 2 DOWN, 3 ERR.
err_clr  input  1  synchronous clear of err_count.
err_count  output  ECNT_BITS  saturating count of ERR steps.

Behaviour:
- Reset values: out_val=0, out=0, out_step=0, err_count=0, prev_bin=0, have_prev=0.
  - Reset is asynchronous and active-high; it takes effect immediately, mid-transfer included.
  - A pending output is discarded on reset.
- Decode rule: b[NBITS-1] = g[NBITS-1]; b[i] = b[i+1] XOR g[i] for i from NBITS-2 down to 0.
- Handshake:
  - in_rdy = !out_val || out_rdy, combinational.
  - Accept on in_val && in_rdy; the result registers next cycle, giving 1-cycle latency.
  - Output fires on out_val && out_rdy.
  - Same-cycle fire plus accept is allowed: the new result replaces the old one with no bubble, giving full throughput.
  - When out_rdy=0, out, out_step and out_val hold stable and no input is consumed.
  - Fire without accept clears out_val.
- Step classification, evaluated on each accept with d = (bin - prev_bin) mod 2^NBITS:
  - have_prev=0 gives HOLD for the first sample after reset.
  - d==0 gives HOLD.
  - d==1 gives UP.
  - d==2^NBITS-1 gives DOWN.
  - Anything else gives ERR.
  - Wrap-around is legal: 2^NBITS-1 to 0 is UP, and 0 to 2^NBITS-1 is DOWN.
- History: every accepted sample, ERR included, updates prev_bin to bin and sets have_prev=1. Classification therefore resynchronizes after a jump.
- err_count:
  - Increments by 1 on each accepted ERR sample and saturates at 2^ECNT_BITS-1.
  - err_clr zeroes it. If err_clr and an ERR accept occur in the same cycle, the result is 1.
  - err_count updates in the cycle the ERR result registers; it does not wait for output fire.
- No combinational path exists from in_ or in_val to out or out_val. The only combinational path is out_rdy to in_rdy.

Test Plan:
- Reset, then idle -> out_val=0, in_rdy=1, err_count=0. Asserting reset while out_val=1 -> out_val=0 immediately, before the next edge.
- Stream Gray 0000, 0001, 0011, 0010, 0110 with out_rdy=1 held -> results 0, 1, 2, 3, 4 with steps HOLD, UP, UP, UP, UP. Each result appears one cycle after its accept, one per cycle, in_rdy constantly 1.
- Wrap: send 1000, 0000, 1000 -> results 15 HOLD, 0 UP, 15 DOWN. Repeat 1000 -> 15 HOLD.
- Error and resync:
  - Send 0000 then 0011 -> results 0 HOLD, then 2 ERR; err_count=1.
  - Next send 0010 -> 3 UP.
  - Asserting err_clr on the cycle 0011 is accepted -> err_count=1; a later lone err_clr -> 0.
- Backpressure: hold out_rdy=0 with result 1 pending and in_val=1, in_=0011 -> in_rdy=0, and out, out_step stay 1/UP for 5 cycles. Raising out_rdy -> 1 fires, 2 UP registers the next cycle, and no samples are lost or duplicated.
- Saturation with ECNT_BITS=2: alternate 0000 and 0101 for 5 pairs -> err_count sticks at 3 and does not wrap.
